// File: rtl/sort_regfile_pkg.sv
// rtl/sort_regfile_pkg.sv - shared defaults and drain FSM states for the sort register file
package sort_regfile_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sort_rf_stream_out.sv
// rtl/sort_rf_stream_out.sv - drain FSM streaming entries 0..DEPTH-1 out in order
// Ports: clock/reset (async active-low), out_start (begin drain when idle),
//        out_ready (sink accepts), entries (flattened register contents),
//        out_valid/out_data/out_last (stream beat, last on entry DEPTH-1).
module sort_rf_stream_out
    import sort_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     out_start,
    input  logic                     out_ready,
    input  logic [DEPTH*WIDTH-1:0]   entries,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last
);

    drain_state_t    state, state_next;
    logic [AW-1:0]   idx, idx_next;
    logic            last_idx;

    assign last_idx = (idx == AW'(DEPTH - 1));

    // Data is a live view of the current entry: it only moves when idx
    // advances (or the entry itself is rewritten), so it is stable on stalls.
    assign out_data = entries[idx*WIDTH +: WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (out_start) begin
                    state_next = DRAIN;
                    idx_next   = '0;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = last_idx;
                if (out_ready) begin
                    if (last_idx) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/sort_regfile.sv
// rtl/sort_regfile.sv - parametrised register file with stream loader, random write and swap ports
// Optional feature macro: SORT_RF_STREAM_OUT_EN (adds the out_* drain stream).
// Ports: clock/reset (async active-low); ld_clear/ld_valid/ld_ready/ld_data (fill loader);
//        wr_en/wr_addr/wr_data (random write); sw_en/sw_addr_a/sw_addr_b (swap);
//        rd_bus (all entries, entry i at [i*WIDTH +: WIDTH]); fill_cnt; loaded.
module sort_regfile
    import sort_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ld_clear,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     sw_en,
    input  logic [AW-1:0]            sw_addr_a,
    input  logic [AW-1:0]            sw_addr_b,
    output logic [DEPTH*WIDTH-1:0]   rd_bus,
`ifdef SORT_RF_STREAM_OUT_EN
    input  logic                     out_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
`endif
    output logic [AW:0]              fill_cnt,
    output logic                     loaded
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic             ld_fire;
    logic             sw_ok;

    assign loaded   = (fill_cnt == DEPTH_W);
    assign ld_ready = !loaded;

    // ld_clear wins over a handshake in the same cycle: nothing is written.
    assign ld_fire = ld_valid && ld_ready && !ld_clear;

    // Any out-of-range address or a == b turns the whole swap into a no-op.
    assign sw_ok = sw_en
                && ({1'b0, sw_addr_a} < DEPTH_W)
                && ({1'b0, sw_addr_b} < DEPTH_W)
                && (sw_addr_a != sw_addr_b);

    // Later assignments override earlier ones, giving wr > swap > load per entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
            if (ld_fire && (fill_cnt == (AW+1)'(i)))
                mem_next[i] = ld_data;
            if (sw_ok && (sw_addr_a == AW'(i)))
                mem_next[i] = mem[sw_addr_b];
            else if (sw_ok && (sw_addr_b == AW'(i)))
                mem_next[i] = mem[sw_addr_a];
            if (wr_en && (wr_addr == AW'(i)))
                mem_next[i] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            fill_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= mem_next[i];
            if (ld_clear)
                fill_cnt <= '0;
            else if (ld_fire)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign rd_bus[g*WIDTH +: WIDTH] = mem[g];
    end

`ifdef SORT_RF_STREAM_OUT_EN
    sort_rf_stream_out #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stream_out (
        .clock     (clock),
        .reset     (reset),
        .out_start (out_start),
        .out_ready (out_ready),
        .entries   (rd_bus),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );
`endif

endmodule

// File: tb/tb_sort_regfile.sv
// tb/tb_sort_regfile.sv - self-checking bench for sort_regfile against a behavioural array model
module tb_sort_regfile;

    localparam int W = 8;
    localparam int D = 32;
    localparam int A = 5;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           ld_clear = 1'b0;
    logic           ld_valid = 1'b0;
    logic           ld_ready;
    logic [W-1:0]   ld_data = '0;
    logic           wr_en = 1'b0;
    logic [A-1:0]   wr_addr = '0;
    logic [W-1:0]   wr_data = '0;
    logic           sw_en = 1'b0;
    logic [A-1:0]   sw_addr_a = '0;
    logic [A-1:0]   sw_addr_b = '0;
    logic [D*W-1:0] rd_bus;
    logic [A:0]     fill_cnt;
    logic           loaded;
`ifdef SORT_RF_STREAM_OUT_EN
    logic           out_start = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_last;
`endif

    sort_regfile dut (
        .clock     (clock),
        .reset     (reset),
        .ld_clear  (ld_clear),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sw_en     (sw_en),
        .sw_addr_a (sw_addr_a),
        .sw_addr_b (sw_addr_b),
        .rd_bus    (rd_bus),
`ifdef SORT_RF_STREAM_OUT_EN
        .out_start (out_start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`endif
        .fill_cnt  (fill_cnt),
        .loaded    (loaded)
    );

    always #5 clock = ~clock;

    int model [D];
    int mcnt;
    int checks = 0;
    int errors = 0;

    function automatic logic [D*W-1:0] model_bus();
        logic [D*W-1:0] b;
        for (int i = 0; i < D; i++)
            b[i*W +: W] = model[i][W-1:0];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [D*W-1:0] obs, input logic [D*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic entry_chk(input string tag, input int idx, input int exp);
        logic [W-1:0] v;
        v = rd_bus[idx*W +: W];
        chk(tag, {{(D*W-W){1'b0}}, v}, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++)
            model[i] = 0;
        mcnt = 0;
    endtask

    task automatic idle_inputs();
        ld_clear = 1'b0;
        ld_valid = 1'b0;
        wr_en    = 1'b0;
        sw_en    = 1'b0;
    endtask

    // One clock: predict from the current inputs (load, then swap of old
    // values, then write on top), advance the clock, compare everything.
    task automatic cycle();
        int  nm [D];
        bit  fire;
        nm   = model;
        fire = ld_valid && (mcnt < D) && !ld_clear;
        if (fire)
            nm[mcnt] = ld_data;
        if (sw_en && (sw_addr_a != sw_addr_b)) begin
            nm[sw_addr_a] = model[sw_addr_b];
            nm[sw_addr_b] = model[sw_addr_a];
        end
        if (wr_en)
            nm[wr_addr] = wr_data;
        if (ld_clear)
            mcnt = 0;
        else if (fire)
            mcnt++;
        @(posedge clock);
        #1;
        model = nm;
        chk("rd_bus", rd_bus, model_bus());
        chk("fill_cnt", fill_cnt, mcnt);
        chk("loaded", loaded, mcnt == D);
        chk("ld_ready", ld_ready, mcnt != D);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < D; i++) begin
            ld_valid = 1'b1;
            ld_data  = W'(8'h20 + i);
            cycle();
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_bus", rd_bus, '0);
        chk("reset_fill", fill_cnt, 0);
        chk("reset_loaded", loaded, 1'b0);
        chk("reset_ready", ld_ready, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        // Fill with 0x20..0x3F
        load_ramp();
        for (int i = 0; i < D; i++)
            entry_chk("t1_entry", i, 8'h20 + i);
        chk("t1_loaded", loaded, 1'b1);
        chk("t1_ready", ld_ready, 1'b0);

        // Loads while full are refused
        ld_valid = 1'b1;
        ld_data  = 8'hAA;
        repeat (3) cycle();
        ld_valid = 1'b0;
        chk("t2_fill", fill_cnt, 32);

        // Swap, then self-swap
        sw_en = 1'b1; sw_addr_a = 5'd3; sw_addr_b = 5'd17;
        cycle();
        entry_chk("t3_e3", 3, 8'h31);
        entry_chk("t3_e17", 17, 8'h23);
        sw_addr_a = 5'd5; sw_addr_b = 5'd5;
        cycle();
        entry_chk("t3_e5", 5, 8'h25);

        // Write beats swap on a shared address
        sw_addr_a = 5'd2; sw_addr_b = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 8'h77;
        cycle();
        idle_inputs();
        entry_chk("t4_e2", 2, 8'h29);
        entry_chk("t4_e9", 9, 8'h77);

        // Clear overrides a load in the same cycle
        ld_clear = 1'b1; ld_valid = 1'b1; ld_data = 8'h55;
        cycle();
        chk("t5_fill_clr", fill_cnt, 0);
        ld_clear = 1'b0; ld_data = 8'h66;
        cycle();
        entry_chk("t5_e0", 0, 8'h66);
        for (int i = 0; i < 9; i++) begin
            ld_data = W'($urandom);
            cycle();
        end
        ld_valid = 1'b0;
        chk("t5_fill10", fill_cnt, 10);

        // Asynchronous reset mid-cycle
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_bus", rd_bus, '0);
        chk("t5_rst_fill", fill_cnt, 0);
        chk("t5_rst_loaded", loaded, 1'b0);
        chk("t5_rst_ready", ld_ready, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        // Randomised mix of all ports
        for (int n = 0; n < 400; n++) begin
            ld_valid  = ($urandom_range(0, 3) != 0);
            ld_clear  = ($urandom_range(0, 23) == 0);
            ld_data   = W'($urandom);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = A'($urandom);
            wr_data   = W'($urandom);
            sw_en     = ($urandom_range(0, 2) == 0);
            sw_addr_a = A'($urandom);
            sw_addr_b = ($urandom_range(0, 5) == 0) ? sw_addr_a : A'($urandom);
            cycle();
        end
        idle_inputs();

`ifdef SORT_RF_STREAM_OUT_EN
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        chk("t6_valid_rst", out_valid, 1'b0);
        load_ramp();
        out_start = 1'b1;
        cycle();
        out_start = 1'b0;
        begin
            int  beat;
            bit  rdy;
            beat = 0;
            rdy  = 1'b1;
            for (int n = 0; n < 200 && beat < D; n++) begin
                out_ready = rdy;
                chk("t6_valid", out_valid, 1'b1);
                chk("t6_data", out_data, 8'h20 + beat);
                chk("t6_last", out_last, beat == D - 1);
                if (rdy)
                    beat++;
                rdy = !rdy;
                cycle();
            end
            out_ready = 1'b0;
            chk("t6_beats", beat, D);
            chk("t6_idle", out_valid, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
